// File: rtl/modulation_timer.sv
// Per-segment modulation sync index: (SYS_TIME / FREQ_DIV) mod (CYCLE + 1).
// Each segment runs a free-running 130-cycle engine: LATCH, 64-step divide, 64-step modulo, OUT.
`timescale 1ns/1ps
module modulation_timer #(
  parameter int NumSegment = 2
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic [63:0] SYS_TIME,
  input  logic [15:0] FREQ_DIV   [NumSegment],
  input  logic [14:0] CYCLE      [NumSegment],
  output logic [14:0] SYNC_IDX   [NumSegment],
  output logic        IDX_UPDATE [NumSegment]
);

  typedef enum logic [1:0] {ST_LATCH, ST_DIV, ST_MOD, ST_OUT} state_t;

  for (genvar g = 0; g < NumSegment; g++) begin : g_seg
    state_t      r_state, w_state;
    logic [5:0]  r_cnt, w_cnt;
    logic [63:0] r_quo, w_quo;
    logic [15:0] r_rem, w_rem;
    logic [15:0] r_div, w_div;
    logic [15:0] r_mod, w_mod;
    logic [14:0] r_idx, w_idx;
    logic        r_upd, w_upd;
    logic [16:0] w_trial;
    logic [15:0] w_den;
    logic [15:0] w_diff;
    logic [15:0] w_step;
    logic        w_ge;

    // One restoring step shared by DIV and MOD; only the denominator differs.
    // A successful subtract always leaves less than the 16-bit denominator,
    // so the 16-bit difference is exact.
    always_comb begin
      w_den   = (r_state == ST_MOD) ? r_mod : r_div;
      w_trial = {r_rem, r_quo[63]};
      w_ge    = (w_trial >= {1'b0, w_den});
      w_diff  = w_trial[15:0] - w_den;
      w_step  = w_ge ? w_diff : w_trial[15:0];
    end

    always_comb begin
      w_state = r_state;
      w_cnt   = r_cnt;
      w_quo   = r_quo;
      w_rem   = r_rem;
      w_div   = r_div;
      w_mod   = r_mod;
      w_idx   = r_idx;
      w_upd   = 1'b0;
      unique case (r_state)
        ST_LATCH: begin
          w_quo   = SYS_TIME;
          w_div   = FREQ_DIV[g];
          w_mod   = {1'b0, CYCLE[g]} + 16'd1;
          w_rem   = '0;
          w_cnt   = '0;
          w_state = ST_DIV;
        end
        ST_DIV: begin
          // The dividend shifts out of the top as quotient bits shift in.
          w_quo = {r_quo[62:0], w_ge};
          w_rem = w_step;
          w_cnt = r_cnt + 6'd1;
          if (r_cnt == 6'd63) begin
            w_rem   = '0;
            w_cnt   = '0;
            w_state = ST_MOD;
          end
        end
        ST_MOD: begin
          w_quo = {r_quo[62:0], 1'b0};
          w_rem = w_step;
          w_cnt = r_cnt + 6'd1;
          if (r_cnt == 6'd63) begin
            w_state = ST_OUT;
          end
        end
        ST_OUT: begin
          // A zero divider would leave an all-ones quotient; publish 0 instead.
          w_idx   = (r_div == 16'd0) ? 15'd0 : r_rem[14:0];
          w_upd   = 1'b1;
          w_cnt   = '0;
          w_state = ST_LATCH;
        end
        default: w_state = ST_LATCH;
      endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
        r_state <= ST_LATCH;
        r_cnt   <= '0;
        r_quo   <= '0;
        r_rem   <= '0;
        r_div   <= '0;
        r_mod   <= '0;
        r_idx   <= '0;
        r_upd   <= 1'b0;
      end else begin
        r_state <= w_state;
        r_cnt   <= w_cnt;
        r_quo   <= w_quo;
        r_rem   <= w_rem;
        r_div   <= w_div;
        r_mod   <= w_mod;
        r_idx   <= w_idx;
        r_upd   <= w_upd;
      end
    end

    assign SYNC_IDX[g]   = r_idx;
    assign IDX_UPDATE[g] = r_upd;
  end

endmodule

// File: tb/tb_modulation_timer.sv
// Scoreboard bench for modulation_timer: expected indices are queued at each LATCH edge and
// popped by a monitor when IDX_UPDATE is due, 129 edges later.
`timescale 1ns/1ps
module tb_modulation_timer;
  localparam int NSEG = 2;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic [63:0] SYS_TIME;
  logic [15:0] FREQ_DIV   [NSEG];
  logic [14:0] CYCLE      [NSEG];
  logic [14:0] SYNC_IDX   [NSEG];
  logic        IDX_UPDATE [NSEG];

  modulation_timer #(.NumSegment(NSEG)) dut (
    .CLK        (CLK),
    .RST_N      (RST_N),
    .SYS_TIME   (SYS_TIME),
    .FREQ_DIV   (FREQ_DIV),
    .CYCLE      (CYCLE),
    .SYNC_IDX   (SYNC_IDX),
    .IDX_UPDATE (IDX_UPDATE)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int                     due;
    bit                     fr;
    logic [NSEG-1:0][14:0]  idx;
  } exp_t;

  exp_t                  sb[$];
  int                    checks = 0;
  int                    errors = 0;
  int                    edge_idx = -1;
  bit                    freerun = 1'b0;
  logic [NSEG-1:0][14:0] last = '0;
  logic [14:0]           prev_fr = '0;
  bit                    have_prev = 1'b0;

  function automatic logic [14:0] model(longint unsigned t, longint unsigned fd, longint unsigned cy);
    if (fd == 0) return 15'd0;
    return 15'((t / fd) % (cy + 1));
  endfunction

  task automatic check(input string name, input longint unsigned act, input longint unsigned req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    end
  endtask

  // Reference schedule: a LATCH occurs on edge 0 after reset release and every 130 edges after.
  always @(posedge CLK or negedge RST_N) begin : model_proc
    exp_t e;
    if (!RST_N) begin
      edge_idx = -1;
      sb.delete();
    end else begin
      edge_idx++;
      if (edge_idx % 130 == 0) begin
        e.due = edge_idx + 129;
        e.fr  = freerun;
        for (int i = 0; i < NSEG; i++) e.idx[i] = model(SYS_TIME, FREQ_DIV[i], CYCLE[i]);
        sb.push_back(e);
      end
    end
  end

  always @(negedge CLK) begin : monitor
    exp_t e;
    int   d;
    if (!RST_N) begin
      last      = '0;
      have_prev = 1'b0;
    end else if (edge_idx >= 0) begin
      check("upd_lockstep", IDX_UPDATE[1], IDX_UPDATE[0]);
      if (sb.size() > 0 && sb[0].due == edge_idx) begin
        e = sb.pop_front();
        check("upd_pulse", IDX_UPDATE[0], 1);
        for (int i = 0; i < NSEG; i++)
          check($sformatf("sync_idx_seg%0d", i), SYNC_IDX[i], e.idx[i]);
        if (e.fr) begin
          if (have_prev) begin
            d = (int'(SYNC_IDX[0]) - int'(prev_fr) + 8) % 8;
            check("freerun_step_gt1", (d > 1) ? 1 : 0, 0);
          end
          prev_fr   = SYNC_IDX[0];
          have_prev = 1'b1;
        end else begin
          have_prev = 1'b0;
        end
        last = e.idx;
      end else begin
        check("upd_idle", IDX_UPDATE[0], 0);
        for (int i = 0; i < NSEG; i++)
          check($sformatf("hold_seg%0d", i), SYNC_IDX[i], last[i]);
      end
    end
  end

  task automatic drive_period(input logic [63:0] t, input logic [15:0] fd0, input logic [14:0] cy0,
                              input logic [15:0] fd1, input logic [14:0] cy1);
    SYS_TIME    = t;
    FREQ_DIV[0] = fd0;
    CYCLE[0]    = cy0;
    FREQ_DIV[1] = fd1;
    CYCLE[1]    = cy1;
    repeat (130) begin
      @(negedge CLK);
      if (freerun) SYS_TIME = SYS_TIME + 64'd1;
    end
  endtask

  initial begin
    logic [15:0] fd0, fd1;
    RST_N       = 1'b0;
    SYS_TIME    = '0;
    FREQ_DIV[0] = '0;
    FREQ_DIV[1] = '0;
    CYCLE[0]    = '0;
    CYCLE[1]    = '0;
    repeat (3) @(negedge CLK);
    #1;
    for (int i = 0; i < NSEG; i++) begin
      check("reset_idx", SYNC_IDX[i], 0);
      check("reset_upd", IDX_UPDATE[i], 0);
    end
    @(negedge CLK);
    RST_N = 1'b1;

    drive_period(64'd1000, 16'd10, 15'd9, 16'd10, 15'd9);
    drive_period(64'd1234567, 16'd512, 15'd3999, 16'd1, 15'd99);
    drive_period((64'd1 << 40) + 64'd5, 16'd1, 15'd32767, 16'd1, 15'd32767);
    drive_period(64'hFFFF_FFFF_FFFF_FFFF, 16'd65535, 15'd32767, 16'd65535, 15'd32767);
    drive_period({$urandom, $urandom}, 16'd0, 15'd100, 16'd0, 15'd100);
    drive_period({$urandom, $urandom}, 16'd0, 15'd100, 16'd3, 15'd0);

    for (int k = 0; k < 8; k++) begin
      fd0 = ($urandom_range(0, 5) == 0) ? 16'd0 : 16'($urandom);
      fd1 = ($urandom_range(0, 1) == 0) ? 16'($urandom_range(1, 300)) : 16'($urandom);
      drive_period({$urandom, $urandom}, fd0, 15'($urandom), fd1, 15'($urandom));
    end

    freerun = 1'b1;
    drive_period(64'd5000, 16'd256, 15'd7, 16'd300, 15'd7);
    repeat (32) drive_period(SYS_TIME, 16'd256, 15'd7, 16'd300, 15'd7);
    freerun = 1'b0;

    drive_period(64'd17, 16'd1, 15'd99, 16'd1, 15'd99);
    SYS_TIME = 64'd123456789;
    repeat (41) @(negedge CLK);
    check("pre_reset_idx", SYNC_IDX[0], 17);
    #2 RST_N = 1'b0;
    #1;
    for (int i = 0; i < NSEG; i++) begin
      check("abort_idx", SYNC_IDX[i], 0);
      check("abort_upd", IDX_UPDATE[i], 0);
    end
    repeat (3) @(negedge CLK);
    RST_N = 1'b1;
    drive_period(64'd99999, 16'd7, 15'd50, 16'd3, 15'd1000);
    drive_period(64'd424242, 16'd130, 15'd255, 16'd65535, 15'd0);
    drive_period(64'd1, 16'd1, 15'd1, 16'd1, 15'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
